id_operand_read: RTL and testbench
==================================

// Module: id_operand_read
// PURPOSE
//  Read side of the write-back path: owns the 32x32 GPR file written by WB and serves ID-stage rs/rt operands.
//  Operands come from the file, or forwarded from MEM (ALU result) / WB (final write data); write-through bypass.
//  Detects RAW hazards that forwarding cannot cover, asserts stall to freeze PC/IF-ID and bubble ID/EX.
//  Keeps a saturating stall-cycle counter for performance bring-up.
// PARAMETERS
//  XLEN     32  data width of registers and operands
//  NREGS    32  number of GPRs; r0 hardwired to zero
//  AW       5   register address width, $clog2(NREGS)
//  CNTW     32  width of stall_cnt
// PORTS
//  clk           in   1     pipeline clock
//  rst           in   1     reset, asynchronous, active-high
//  wb_reg_write  in   1     WB stage writes the register file this cycle
//  wb_waddr      in   AW    WB destination register
//  wb_data       in   XLEN  WB write data (0 when wb_reg_write=0)
//  mem_reg_write in   1     instruction in MEM writes a register
//  mem_memtoreg  in   1     instruction in MEM is a load (data not yet available)
//  mem_waddr     in   AW    MEM destination register
//  mem_alu       in   XLEN  MEM-stage ALU result (forwardable when !mem_memtoreg)
//  ex_reg_write  in   1     instruction in EX writes a register
//  ex_waddr      in   AW    EX destination register
//  id_valid      in   1     ID holds a real instruction
//  id_rs         in   AW    source register rs
//  id_rt         in   AW    source register rt
//  rs_data       out  XLEN  resolved rs operand (combinational)
//  rt_data       out  XLEN  resolved rt operand (combinational)
//  stall         out  1     freeze IF/ID, inject bubble into ID/EX (combinational)
//  stall_cnt     out  CNTW  cycles with stall=1 since reset, saturating
// BEHAVIOUR
//  Reset (async, rst=1): all GPRs <= 0, stall_cnt <= 0; reads then return 0; stall depends only on inputs.
//  Write: posedge clk, wb_reg_write && wb_waddr!=0 -> GPR[wb_waddr] <= wb_data. Writes to r0 dropped.
//  Per operand src (rs, rt), priority highest first:
//   1 src==0                                     -> 0 (never forwarded, never stalls)
//   2 mem_reg_write && !mem_memtoreg && mem_waddr==src -> mem_alu
//   3 wb_reg_write && wb_waddr==src              -> wb_data (same-cycle write-through)
//   4 otherwise                                  -> GPR[src]
//  MEM beats WB when both match (younger producer wins).
//  Hazard for src (src!=0 && id_valid):
//   ex_reg_write && ex_waddr==src                -> hazard (any EX producer; result reaches MEM next cycle)
//   mem_reg_write && mem_memtoreg && mem_waddr==src -> hazard (load data reaches WB next cycle)
//  stall = hazard(rs) | hazard(rt). Load in EX therefore stalls 2 cycles, ALU op in EX 1 cycle.
//  Operand values during stall are don't-care to downstream (bubble injected), but must still follow priority.
//  stall_cnt: posedge clk, stall=1 and stall_cnt!=all-ones -> +1; holds at 2^CNTW-1.
//  rst asserted mid-operation: GPRs and counter clear immediately; no partial write completes.
//  Latency: write visible to ID in the same cycle via bypass, from file next cycle.
// STRUCTURE
//  cpu_pkg: XLEN, REG_AW, REG_ZERO constant, typedef enum fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_ZERO}.
//  Sub-module operand_fwd_mux: one src address + sources -> fwd_sel_e and data, plus hazard bit;
//  instantiated twice (rs, rt). Register array and stall_cnt live in id_operand_read.
// TESTING
//  T1 reset: rst=1 mid-run after writing r5=0xDEADBEEF -> rs_data(r5)=0, stall_cnt=0 immediately.
//  T2 r0: WB writes r0=0x1234, MEM fwd r0=0x55 -> rs_data(r0)=0, stall=0; next cycle still 0.
//  T3 bypass: WB writes r7=0xA5A5A5A5, id_rs=7 same cycle -> rs_data=0xA5A5A5A5; next cycle from file, same value.
//  T4 priority: MEM alu r3=0x11, WB r3=0x22, id_rt=3 -> rt_data=0x11; drop MEM match -> 0x22.
//  T5 load-use: lw r4 in EX, id_rs=4 -> stall 1 cycle, then lw in MEM -> stall 1 more,
//     then WB r4=0x99 -> rs_data=0x99, stall=0; stall_cnt advanced by 2.
//  T6 counter: CNTW=4, hold hazard 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared constants and types for the ID-stage operand read path.
//   XLEN     : register/operand data width
//   REG_AW   : register address width
//   REG_ZERO : address of the hardwired-zero register
//   fwd_sel_e: which source an operand is taken from
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux
//   Resolves one ID-stage source operand and flags whether it has an
//   unresolvable RAW hazard against an older in-flight producer.
// Ports
//   src            in   AW    source register address
//   id_valid       in   1     ID holds a real instruction
//   mem_reg_write  in   1     MEM instruction writes a register
//   mem_memtoreg   in   1     MEM instruction is a load
//   mem_waddr      in   AW    MEM destination
//   mem_alu        in   XLEN  MEM ALU result
//   wb_reg_write   in   1     WB writes the register file this cycle
//   wb_waddr       in   AW    WB destination
//   wb_data        in   XLEN  WB write data
//   ex_reg_write   in   1     EX instruction writes a register
//   ex_waddr       in   AW    EX destination
//   rf_data        in   XLEN  register file read value for src
//   data           out  XLEN  resolved operand
//   hazard         out  1     operand cannot be forwarded yet
module operand_fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned XW = XLEN,
  parameter int unsigned AW = REG_AW
) (
  input  logic [AW-1:0] src,
  input  logic          id_valid,
  input  logic          mem_reg_write,
  input  logic          mem_memtoreg,
  input  logic [AW-1:0] mem_waddr,
  input  logic [XW-1:0] mem_alu,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_waddr,
  input  logic [XW-1:0] wb_data,
  input  logic          ex_reg_write,
  input  logic [AW-1:0] ex_waddr,
  input  logic [XW-1:0] rf_data,
  output logic [XW-1:0] data,
  output logic          hazard
);

  fwd_sel_e sel;
  logic     src_nz;

  assign src_nz = (src != AW'(REG_ZERO));

  // Source selection: the younger producer (MEM) wins over WB, and a load
  // sitting in MEM has no data yet so it is never a forwarding source.
  always_comb begin
    sel = FWD_RF;
    if (!src_nz)
      sel = FWD_ZERO;
    else if (mem_reg_write && !mem_memtoreg && (mem_waddr == src))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_waddr == src))
      sel = FWD_WB;
  end

  // Operand data driven from the selected source.
  always_comb begin
    data = rf_data;
    unique case (sel)
      FWD_ZERO: data = '0;
      FWD_MEM:  data = mem_alu;
      FWD_WB:   data = wb_data;
      default:  data = rf_data;
    endcase
  end

  // Any EX producer is one cycle too early to forward; a load in MEM has
  // its data only once it reaches WB.
  always_comb begin
    hazard = 1'b0;
    if (src_nz && id_valid) begin
      if (ex_reg_write && (ex_waddr == src))
        hazard = 1'b1;
      if (mem_reg_write && mem_memtoreg && (mem_waddr == src))
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/id_operand_read.sv
// id_operand_read
//   Owns the GPR file written by WB and serves resolved rs/rt operands to ID,
//   with MEM/WB forwarding, write-through bypass, hazard stall and a
//   saturating stall-cycle counter.
// Ports
//   clk, rst                      clock, async active-high reset
//   wb_reg_write/wb_waddr/wb_data WB register file write
//   mem_reg_write/mem_memtoreg/mem_waddr/mem_alu  MEM producer
//   ex_reg_write/ex_waddr         EX producer
//   id_valid/id_rs/id_rt          ID stage sources
//   rs_data/rt_data               resolved operands (combinational)
//   stall                         freeze IF/ID, bubble ID/EX (combinational)
//   stall_cnt                     saturating count of stalled cycles
module id_operand_read
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter int unsigned CNTW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [AW-1:0]     wb_waddr,
  input  logic [XLEN_P-1:0] wb_data,
  input  logic              mem_reg_write,
  input  logic              mem_memtoreg,
  input  logic [AW-1:0]     mem_waddr,
  input  logic [XLEN_P-1:0] mem_alu,
  input  logic              ex_reg_write,
  input  logic [AW-1:0]     ex_waddr,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  output logic [XLEN_P-1:0] rs_data,
  output logic [XLEN_P-1:0] rt_data,
  output logic              stall,
  output logic [CNTW-1:0]   stall_cnt
);

  logic [XLEN_P-1:0] gpr [NREGS];
  logic              rs_hazard;
  logic              rt_hazard;

  // Register file: r0 is never written, so it reads as zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++)
        gpr[i] <= '0;
    end else if (wb_reg_write && (wb_waddr != AW'(REG_ZERO))) begin
      gpr[wb_waddr] <= wb_data;
    end
  end

  operand_fwd_mux #(.XW(XLEN_P), .AW(AW)) u_rs_mux (
    .src           (id_rs),
    .id_valid      (id_valid),
    .mem_reg_write (mem_reg_write),
    .mem_memtoreg  (mem_memtoreg),
    .mem_waddr     (mem_waddr),
    .mem_alu       (mem_alu),
    .wb_reg_write  (wb_reg_write),
    .wb_waddr      (wb_waddr),
    .wb_data       (wb_data),
    .ex_reg_write  (ex_reg_write),
    .ex_waddr      (ex_waddr),
    .rf_data       (gpr[id_rs]),
    .data          (rs_data),
    .hazard        (rs_hazard)
  );

  operand_fwd_mux #(.XW(XLEN_P), .AW(AW)) u_rt_mux (
    .src           (id_rt),
    .id_valid      (id_valid),
    .mem_reg_write (mem_reg_write),
    .mem_memtoreg  (mem_memtoreg),
    .mem_waddr     (mem_waddr),
    .mem_alu       (mem_alu),
    .wb_reg_write  (wb_reg_write),
    .wb_waddr      (wb_waddr),
    .wb_data       (wb_data),
    .ex_reg_write  (ex_reg_write),
    .ex_waddr      (ex_waddr),
    .rf_data       (gpr[id_rt]),
    .data          (rt_data),
    .hazard        (rt_hazard)
  );

  assign stall = rs_hazard | rt_hazard;

  // Stall-cycle counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_id_operand_read.sv
// tb_id_operand_read
//   Directed bench for id_operand_read: a default-width instance plus a
//   4-bit-counter instance sharing the same stimulus.
module tb_id_operand_read;

  logic        clk;
  logic        rst;
  logic        wb_reg_write;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;
  logic        mem_reg_write;
  logic        mem_memtoreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu;
  logic        ex_reg_write;
  logic [4:0]  ex_waddr;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] rs_data, rt_data;
  logic        stall;
  logic [31:0] stall_cnt;
  logic [31:0] rs_data4, rt_data4;
  logic        stall4;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  id_operand_read dut (
    .clk(clk), .rst(rst),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .mem_waddr(mem_waddr), .mem_alu(mem_alu),
    .ex_reg_write(ex_reg_write), .ex_waddr(ex_waddr),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .stall_cnt(stall_cnt)
  );

  id_operand_read #(.CNTW(4)) dut4 (
    .clk(clk), .rst(rst),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_data(wb_data),
    .mem_reg_write(mem_reg_write), .mem_memtoreg(mem_memtoreg),
    .mem_waddr(mem_waddr), .mem_alu(mem_alu),
    .ex_reg_write(ex_reg_write), .ex_waddr(ex_waddr),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .rs_data(rs_data4), .rt_data(rt_data4), .stall(stall4), .stall_cnt(stall_cnt4)
  );

  // Free-running clock, rising edge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drop every producer/consumer back to idle.
  task automatic applyStimulus();
    wb_reg_write  = 1'b0; wb_waddr  = '0; wb_data = '0;
    mem_reg_write = 1'b0; mem_memtoreg = 1'b0; mem_waddr = '0; mem_alu = '0;
    ex_reg_write  = 1'b0; ex_waddr  = '0;
    id_valid      = 1'b0; id_rs     = '0; id_rt   = '0;
    #1;
  endtask

  // Advance past one rising edge and settle, away from the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus();
    tick(2);
    rst = 1'b0;
    #1;

    // Reset state
    id_rs = 5'd5;
    #1;
    checkOutput("reset_rs", 64'(rs_data), 64'h0);
    checkOutput("reset_stall", 64'(stall), 64'h0);
    checkOutput("reset_cnt", 64'(stall_cnt), 64'h0);

    // T1: write r5, build up some stall count, then reset mid-run
    wb_reg_write = 1'b1; wb_waddr = 5'd5; wb_data = 32'hDEADBEEF;
    tick(1);
    applyStimulus();
    id_rs = 5'd5;
    #1;
    checkOutput("t1_file_r5", 64'(rs_data), 64'hDEADBEEF);
    ex_reg_write = 1'b1; ex_waddr = 5'd5; id_valid = 1'b1;
    #1;
    checkOutput("t1_stall", 64'(stall), 64'h1);
    tick(2);
    checkOutput("t1_cnt_pre", 64'(stall_cnt), 64'h2);
    checkOutput("t1_cnt4_pre", 64'(stall_cnt4), 64'h2);
    applyStimulus();
    id_rs = 5'd5;
    rst = 1'b1;
    #1;
    checkOutput("t1_rst_rs", 64'(rs_data), 64'h0);
    checkOutput("t1_rst_cnt", 64'(stall_cnt), 64'h0);
    tick(1);
    rst = 1'b0;
    #1;
    checkOutput("t1_after_rs", 64'(rs_data), 64'h0);

    // T2: r0 is never forwarded, written or stalled on
    wb_reg_write = 1'b1; wb_waddr = 5'd0; wb_data = 32'h1234;
    mem_reg_write = 1'b1; mem_waddr = 5'd0; mem_alu = 32'h55;
    ex_reg_write = 1'b1; ex_waddr = 5'd0;
    id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checkOutput("t2_r0_fwd", 64'(rs_data), 64'h0);
    checkOutput("t2_r0_stall", 64'(stall), 64'h0);
    tick(1);
    applyStimulus();
    checkOutput("t2_r0_next", 64'(rs_data), 64'h0);
    checkOutput("t2_cnt", 64'(stall_cnt), 64'h0);

    // T3: write-through bypass then file read
    wb_reg_write = 1'b1; wb_waddr = 5'd7; wb_data = 32'hA5A5A5A5;
    id_rs = 5'd7;
    #1;
    checkOutput("t3_bypass", 64'(rs_data), 64'hA5A5A5A5);
    tick(1);
    applyStimulus();
    id_rs = 5'd7;
    #1;
    checkOutput("t3_file", 64'(rs_data), 64'hA5A5A5A5);

    // T4: MEM beats WB; load in MEM is not a forwarding source
    mem_reg_write = 1'b1; mem_waddr = 5'd3; mem_alu = 32'h11;
    wb_reg_write = 1'b1; wb_waddr = 5'd3; wb_data = 32'h22;
    id_valid = 1'b1; id_rt = 5'd3; id_rs = 5'd7;
    #1;
    checkOutput("t4_mem_wins", 64'(rt_data), 64'h11);
    checkOutput("t4_rs_file", 64'(rs_data), 64'hA5A5A5A5);
    mem_reg_write = 1'b0;
    #1;
    checkOutput("t4_wb_only", 64'(rt_data), 64'h22);
    mem_reg_write = 1'b1; mem_memtoreg = 1'b1;
    #1;
    checkOutput("t4_load_nofwd", 64'(rt_data), 64'h22);
    checkOutput("t4_load_stall", 64'(stall), 64'h1);
    applyStimulus();

    // T5: load-use, lw r4 in EX then MEM then WB
    ex_reg_write = 1'b1; ex_waddr = 5'd4; id_valid = 1'b1; id_rs = 5'd4;
    #1;
    checkOutput("t5_ex_stall", 64'(stall), 64'h1);
    tick(1);
    ex_reg_write = 1'b0;
    mem_reg_write = 1'b1; mem_memtoreg = 1'b1; mem_waddr = 5'd4; mem_alu = 32'h4444;
    #1;
    checkOutput("t5_mem_stall", 64'(stall), 64'h1);
    tick(1);
    mem_reg_write = 1'b0; mem_memtoreg = 1'b0;
    wb_reg_write = 1'b1; wb_waddr = 5'd4; wb_data = 32'h99;
    #1;
    checkOutput("t5_wb_data", 64'(rs_data), 64'h99);
    checkOutput("t5_wb_stall", 64'(stall), 64'h0);
    checkOutput("t5_cnt", 64'(stall_cnt), 64'h2);
    tick(1);
    applyStimulus();
    checkOutput("t5_cnt_hold", 64'(stall_cnt), 64'h2);

    // T6: invalid ID never stalls; held hazard saturates the 4-bit counter
    ex_reg_write = 1'b1; ex_waddr = 5'd9; id_rt = 5'd9; id_valid = 1'b0;
    #1;
    checkOutput("t6_invalid", 64'(stall), 64'h0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    id_valid = 1'b1;
    #1;
    checkOutput("t6_rt_stall4", 64'(stall4), 64'h1);
    tick(14);
    checkOutput("t6_cnt4_14", 64'(stall_cnt4), 64'hE);
    tick(6);
    checkOutput("t6_cnt4_sat", 64'(stall_cnt4), 64'hF);
    checkOutput("t6_cnt32", 64'(stall_cnt), 64'd20);
    checkOutput("t6_rt4", 64'(rt_data4), 64'h0);
    checkOutput("t6_rs4", 64'(rs_data4), 64'h0);
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
